vc_ingress_classifier: RTL and testbench

- Transmit-side writer for the four virtual-channel input FIFOs (VC0..VC3). The four-way referee arbiter downstream drains the same FIFOs.
- Accepts one 12-bit transaction word per cycle on a valid/ready stream and classifies it by class field bits [11:10].
- Pushes the word into the matching VC FIFO.
- Honours per-FIFO almost_full backpressure by stalling the stream, never by dropping words.

---
 rtl/vc_ingress_classifier.sv | 175 +++++++++++++++++
 tb/tb_vc_ingress_classifier.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_ingress_classifier.sv
// vc_ingress_classifier
// Writer for the four virtual-channel input FIFOs. Words arrive on a
// valid/ready stream, wait in a one-entry holding register, and are
// pushed into the FIFO selected by the class field [DATA_W-1:DATA_W-2].
// almost_full on the head word's class stalls the stream; nothing is dropped.
// Optional statistics counters are enabled by defining VC_INGRESS_STATS_EN.
module vc_ingress_classifier #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              almost_full_0,
    input  logic              almost_full_1,
    input  logic              almost_full_2,
    input  logic              almost_full_3,
    output logic              push_0,
    output logic              push_1,
    output logic              push_2,
    output logic              push_3,
    output logic [DATA_W-1:0] data_out,
`ifdef VC_INGRESS_STATS_EN
    output logic [CNT_W-1:0]  push_cnt_0,
    output logic [CNT_W-1:0]  push_cnt_1,
    output logic [CNT_W-1:0]  push_cnt_2,
    output logic [CNT_W-1:0]  push_cnt_3,
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic              idle
);

    localparam logic [3:0] ST_INIT = 4'b0001;

    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [3:0]        push_q, push_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic              is_init;
    logic              is_active;
    logic [1:0]        cls;
    logic [3:0]        af_vec;
    logic              af_cls;
    logic              drain;
    logic              accept;

    // Link-state decode, head-word class lookup and stream handshake
    always_comb begin
        is_init   = (state == ST_INIT);
        is_active = (state == 4'b0100) || (state == 4'b1000);
        cls       = hold_data_q[DATA_W-1 -: 2];
        af_vec    = {almost_full_3, almost_full_2, almost_full_1, almost_full_0};
        af_cls    = af_vec[cls];
        drain     = hold_valid_q & is_active & ~af_cls;
        in_ready  = is_active & ~reset & (~hold_valid_q | drain);
        accept    = in_valid & in_ready;
    end

    // Next state of the holding stage and the push/data output register
    always_comb begin
        push_d       = 4'b0000;
        data_out_d   = data_out_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (is_init) begin
            // INIT flushes everything, including any stalled head word
            data_out_d   = '0;
            hold_valid_d = 1'b0;
            hold_data_d  = '0;
        end else if (is_active) begin
            if (drain) begin
                push_d[cls] = 1'b1;
                data_out_d  = hold_data_q;
            end
            if (accept) begin
                hold_data_d  = in_data;
                hold_valid_d = 1'b1;
            end else if (drain) begin
                hold_valid_d = 1'b0;
            end
        end
        // PAUSE: pushes forced low, holding register retained
    end

    // Holding stage and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            push_q       <= 4'b0000;
            data_out_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            push_q       <= push_d;
            data_out_q   <= data_out_d;
        end
    end

    // Output drive and idle indication
    always_comb begin
        push_0   = push_q[0];
        push_1   = push_q[1];
        push_2   = push_q[2];
        push_3   = push_q[3];
        data_out = data_out_q;
        idle     = ~hold_valid_q & ~(|push_q);
    end

`ifdef VC_INGRESS_STATS_EN
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
        return v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] push_cnt_q [4];
    logic [CNT_W-1:0] push_cnt_d [4];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counter updates: pushes counted when issued, stalls on every blocked ACTIVE cycle
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            push_cnt_d[k] = push_cnt_q[k];
        end
        stall_cnt_d = stall_cnt_q;
        if (is_init) begin
            for (int k = 0; k < 4; k++) begin
                push_cnt_d[k] = '0;
            end
            stall_cnt_d = '0;
        end else if (is_active) begin
            for (int k = 0; k < 4; k++) begin
                if (push_d[k]) begin
                    push_cnt_d[k] = wrap_inc(push_cnt_q[k]);
                end
            end
            if (hold_valid_q & af_cls) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                push_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                push_cnt_q[k] <= push_cnt_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Statistics output drive
    always_comb begin
        push_cnt_0 = push_cnt_q[0];
        push_cnt_1 = push_cnt_q[1];
        push_cnt_2 = push_cnt_q[2];
        push_cnt_3 = push_cnt_q[3];
        stall_cnt  = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_vc_ingress_classifier.sv
// Directed bench for vc_ingress_classifier. Inputs change on the falling
// edge; all outputs are sampled 1 time unit later.
module tb_vc_ingress_classifier;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic        in_valid;
    logic [11:0] in_data;
    logic [3:0]  af;
    wire         in_ready;
    wire  [3:0]  push;
    wire  [11:0] data_out;
    wire         idle;
`ifdef VC_INGRESS_STATS_EN
    wire  [7:0]  pc0, pc1, pc2, pc3, sc;
`endif

    int errors = 0;
    int checks = 0;
    int npush1 = 0;
    int rdy_drops = 0;

    always #5 clk = ~clk;

    vc_ingress_classifier #(.DATA_W(12), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .state         (state),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .almost_full_0 (af[0]),
        .almost_full_1 (af[1]),
        .almost_full_2 (af[2]),
        .almost_full_3 (af[3]),
        .push_0        (push[0]),
        .push_1        (push[1]),
        .push_2        (push[2]),
        .push_3        (push[3]),
        .data_out      (data_out),
`ifdef VC_INGRESS_STATS_EN
        .push_cnt_0    (pc0),
        .push_cnt_1    (pc1),
        .push_cnt_2    (pc2),
        .push_cnt_3    (pc3),
        .stall_cnt     (sc),
`endif
        .idle          (idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [3:0] st, input logic v,
                       input logic [11:0] d, input logic [3:0] a);
        @(negedge clk);
        reset    = r;
        state    = st;
        in_valid = v;
        in_data  = d;
        af       = a;
        #1;
    endtask

    initial begin
        reset = 1'b1; state = 4'b0100; in_valid = 1'b0; in_data = '0; af = '0;

        // reset for two edges
        drv(1, 4'b0100, 0, 12'h000, 4'h0);
        drv(1, 4'b0100, 0, 12'h000, 4'h0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_push", push, 4'h0);
        chk("rst_data_out", data_out, 12'h000);
        chk("rst_idle", idle, 1);
`ifdef VC_INGRESS_STATS_EN
        chk("rst_stall_cnt", sc, 0);
`endif

        // streaming, one word of each class back to back
        drv(0, 4'b0100, 1, 12'h000, 4'h0);
        chk("str_rdy0", in_ready, 1);
        drv(0, 4'b0100, 1, 12'h400, 4'h0);
        chk("str_rdy1", in_ready, 1);
        chk("str_no_push_yet", push, 4'h0);
        drv(0, 4'b0100, 1, 12'h800, 4'h0);
        chk("str_rdy2", in_ready, 1);
        chk("str_push0", push, 4'h1);
        chk("str_data0", data_out, 12'h000);
        drv(0, 4'b0100, 1, 12'hC00, 4'h0);
        chk("str_rdy3", in_ready, 1);
        chk("str_push1", push, 4'h2);
        chk("str_data1", data_out, 12'h400);
        drv(0, 4'b0100, 0, 12'h000, 4'h0);
        chk("str_push2", push, 4'h4);
        chk("str_data2", data_out, 12'h800);
        drv(0, 4'b0100, 0, 12'h000, 4'h0);
        chk("str_push3", push, 4'h8);
        chk("str_data3", data_out, 12'hC00);
        chk("str_busy", idle, 0);

        // stall on VC2, second word blocked behind it
        drv(0, 4'b0100, 1, 12'h8A5, 4'h4);
        chk("str_end_push", push, 4'h0);
        chk("str_end_idle", idle, 1);
        chk("hold_data_out", data_out, 12'hC00);
        chk("stl_rdy_empty", in_ready, 1);
        drv(0, 4'b0100, 1, 12'h012, 4'h4);
        chk("stl_rdy_a", in_ready, 0);
        chk("stl_push_a", push, 4'h0);
        drv(0, 4'b0100, 1, 12'h012, 4'h4);
        chk("stl_rdy_b", in_ready, 0);
        chk("stl_push_b", push, 4'h0);
        drv(0, 4'b0100, 1, 12'h012, 4'h0);
        chk("stl_rdy_release", in_ready, 1);
        chk("stl_push_c", push, 4'h0);
        drv(0, 4'b0100, 0, 12'h000, 4'h0);
        chk("stl_push2", push, 4'h4);
        chk("stl_data2", data_out, 12'h8A5);
        drv(0, 4'b0100, 1, 12'h7FF, 4'h0);
        chk("stl_push0", push, 4'h1);
        chk("stl_data0", data_out, 12'h012);
`ifdef VC_INGRESS_STATS_EN
        chk("stl_stall_cnt", sc, 2);
`endif

        // pause with 12'h7FF held
        drv(0, 4'b0010, 0, 12'h000, 4'h0);
        chk("pau_rdy", in_ready, 0);
        chk("pau_push_a", push, 4'h0);
        drv(0, 4'b0010, 0, 12'h000, 4'h0);
        chk("pau_push_b", push, 4'h0);
        chk("pau_not_idle", idle, 0);
        drv(0, 4'b1000, 0, 12'h000, 4'h0);
        chk("pau_rdy_resume", in_ready, 1);
        chk("pau_push_c", push, 4'h0);
        drv(0, 4'b1000, 0, 12'h000, 4'h0);
        chk("pau_push1", push, 4'h2);
        chk("pau_data1", data_out, 12'h7FF);
        drv(0, 4'b0100, 1, 12'hC33, 4'h8);
        chk("pau_single_push", push, 4'h0);
        chk("pau_idle", idle, 1);
`ifdef VC_INGRESS_STATS_EN
        chk("cnt0", pc0, 2);
        chk("cnt1", pc1, 2);
        chk("cnt2", pc2, 2);
        chk("cnt3", pc3, 1);
        chk("cnt_stall_pause", sc, 2);
`endif

        // INIT flush of a stalled 12'hC33
        drv(0, 4'b0100, 0, 12'h000, 4'h8);
        chk("ini_rdy_stall", in_ready, 0);
        chk("ini_push_a", push, 4'h0);
        drv(0, 4'b0001, 0, 12'h000, 4'h8);
        chk("ini_rdy", in_ready, 0);
        drv(0, 4'b0100, 0, 12'h000, 4'h0);
        chk("ini_idle", idle, 1);
        chk("ini_rdy_after", in_ready, 1);
        chk("ini_data_out", data_out, 12'h000);
        chk("ini_push_b", push, 4'h0);
`ifdef VC_INGRESS_STATS_EN
        chk("ini_cnt0", pc0, 0);
        chk("ini_cnt1", pc1, 0);
        chk("ini_cnt3", pc3, 0);
        chk("ini_stall", sc, 0);
`endif
        drv(0, 4'b0100, 0, 12'h000, 4'h0);
        chk("ini_push_c", push, 4'h0);
        drv(0, 4'b0100, 1, 12'h123, 4'h0);
        chk("ini_push_d", push, 4'h0);

        // reset while pushes are active
        drv(0, 4'b0100, 1, 12'h456, 4'h0);
        drv(1, 4'b0100, 1, 12'h789, 4'h0);
        chk("mid_push_before", push, 4'h1);
        chk("mid_data_before", data_out, 12'h123);
        chk("mid_rdy_in_reset", in_ready, 0);
        drv(1, 4'b0100, 0, 12'h000, 4'h0);
        chk("mid_push", push, 4'h0);
        chk("mid_data", data_out, 12'h000);
        chk("mid_rdy", in_ready, 0);
        chk("mid_idle", idle, 1);
        drv(0, 4'b0100, 0, 12'h000, 4'h0);
        chk("mid_no_stale_push", push, 4'h0);

        // 256 words of class 01 at full rate
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo;
            lo = i[7:0];
            drv(0, 4'b0100, 1, {4'h4, lo}, 4'h0);
            npush1 += int'(push[1]);
            if (!in_ready) rdy_drops++;
        end
        for (int i = 0; i < 3; i++) begin
            drv(0, 4'b0100, 0, 12'h000, 4'h0);
            npush1 += int'(push[1]);
        end
        chk("wrap_push1_count", npush1, 256);
        chk("wrap_ready_drops", rdy_drops, 0);
        chk("wrap_idle", idle, 1);
`ifdef VC_INGRESS_STATS_EN
        chk("wrap_cnt1", pc1, 0);
        chk("wrap_cnt0", pc0, 0);
        chk("wrap_cnt2", pc2, 0);
        chk("wrap_cnt3", pc3, 0);
        chk("wrap_stall", sc, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
